// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider driving one shared N+1-bit subtractor
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int W = (N > 2) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [N-1:0] r_q, r_d, q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         dbz_q, dbz_d;
  logic [N:0]   add_x, add_y, add_s;
  logic         add_c, accept, zero, run, fin;
  always_comb begin
    add_x          = {r_q, q_q[N-1]};
    add_y          = {1'b0, d_q};
    {add_c, add_s} = {1'b0, add_x} + {1'b0, ~add_y} + (N+2)'(1);
    accept         = (state_q == IDLE) && start;
    zero           = divisor == '0;
    run            = state_q == RUN;
    fin            = run && (cnt_q == W'(N-1));
    state_d        = accept ? (zero ? DONE : RUN) :
                     run ? (fin ? DONE : RUN) :
                     (state_q == DONE) ? IDLE : state_q;
    r_d            = accept ? '0 : run ? (add_c ? add_s[N-1:0] : add_x[N-1:0]) : r_q;
    q_d            = accept ? dividend : run ? {q_q[N-2:0], add_c} : q_q;
    d_d            = accept ? divisor : d_q;
    cnt_d          = accept ? '0 : run ? cnt_q + W'(1) : cnt_q;
    quot_d         = (accept && zero) ? '1 : fin ? q_d : quot_q;
    rem_d          = (accept && zero) ? dividend : fin ? r_d : rem_q;
    dbz_d          = (accept && zero) ? 1'b1 : fin ? 1'b0 : dbz_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against arithmetic div/mod
module tb_seq_divider;
  logic        clk = 0;
  logic        rst = 1;
  logic        s8_start = 0;
  logic [7:0]  s8_a = 0, s8_b = 0, s8_q, s8_r;
  logic        s8_busy, s8_done, s8_z;
  logic        s16_start = 0;
  logic [15:0] s16_a = 0, s16_b = 0, s16_q, s16_r;
  logic        s16_busy, s16_done, s16_z;
  int          total = 0;
  int          bad = 0;
  seq_divider #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .dividend(s8_a), .divisor(s8_b),
    .busy(s8_busy), .done(s8_done), .quotient(s8_q), .remainder(s8_r), .div_by_zero(s8_z)
  );
  seq_divider #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16_start), .dividend(s16_a), .divisor(s16_b),
    .busy(s16_busy), .done(s16_done), .quotient(s16_q), .remainder(s16_r), .div_by_zero(s16_z)
  );
  always #5 clk = ~clk;
  task automatic go8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bc);
    @(posedge clk); #1;
    s8_a = a;
    s8_b = b;
    s8_start = 1;
    @(posedge clk); #1;
    s8_start = 0;
    lat = -1;
    bc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (s8_busy) bc++;
      if (s8_done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic go16(input logic [15:0] a, input logic [15:0] b, output int lat, output int bc);
    @(posedge clk); #1;
    s16_a = a;
    s16_b = b;
    s16_start = 1;
    @(posedge clk); #1;
    s16_start = 0;
    lat = -1;
    bc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (s16_busy) bc++;
      if (s16_done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset;
    rst = 1;
    s8_a = 5;
    s8_b = 1;
    s8_start = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({s8_busy, s8_done, s8_q, s8_r, s8_z} !== 19'b0) begin
      bad++;
      $display("FAIL reset8 got busy=%b done=%b q=%0d r=%0d z=%b want all 0", s8_busy, s8_done, s8_q, s8_r, s8_z);
    end
    total++;
    if ({s16_busy, s16_done, s16_q, s16_r, s16_z} !== 35'b0) begin
      bad++;
      $display("FAIL reset16 got busy=%b done=%b q=%0d r=%0d z=%b want all 0", s16_busy, s16_done, s16_q, s16_r, s16_z);
    end
    rst = 0;
    s8_start = 0;
  endtask
  task automatic test_basic;
    int lat, bc;
    go8(8'd100, 8'd7, lat, bc);
    total++;
    if (lat !== 9 || bc !== 8 || s8_q !== 8'd14 || s8_r !== 8'd2 || s8_z !== 1'b0) begin
      bad++;
      $display("FAIL basic got lat=%0d busy=%0d q=%0d r=%0d z=%b want lat=9 busy=8 q=14 r=2 z=0", lat, bc, s8_q, s8_r, s8_z);
    end
    @(posedge clk); #1;
    total++;
    if (s8_done !== 1'b0 || s8_q !== 8'd14 || s8_r !== 8'd2) begin
      bad++;
      $display("FAIL done_pulse got done=%b q=%0d r=%0d want done=0 q=14 r=2", s8_done, s8_q, s8_r);
    end
  endtask
  task automatic test_boundaries;
    logic [7:0] ta [5] = '{8'd255, 8'd5, 8'd255, 8'd0, 8'd1};
    logic [7:0] tb [5] = '{8'd1, 8'd9, 8'd255, 8'd3, 8'd255};
    logic [7:0] tq [5] = '{8'd255, 8'd0, 8'd1, 8'd0, 8'd0};
    logic [7:0] tr [5] = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd1};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      go8(ta[i], tb[i], lat, bc);
      total++;
      if (lat !== 9 || bc !== 8 || s8_q !== tq[i] || s8_r !== tr[i] || s8_z !== 1'b0) begin
        bad++;
        $display("FAIL boundary %0d/%0d got lat=%0d busy=%0d q=%0d r=%0d z=%b want lat=9 busy=8 q=%0d r=%0d z=0",
                 ta[i], tb[i], lat, bc, s8_q, s8_r, s8_z, tq[i], tr[i]);
      end
    end
  endtask
  task automatic test_div_zero;
    int lat, bc;
    go8(8'd42, 8'd0, lat, bc);
    total++;
    if (lat !== 1 || bc !== 0 || s8_q !== 8'd255 || s8_r !== 8'd42 || s8_z !== 1'b1) begin
      bad++;
      $display("FAIL div_zero got lat=%0d busy=%0d q=%0d r=%0d z=%b want lat=1 busy=0 q=255 r=42 z=1", lat, bc, s8_q, s8_r, s8_z);
    end
    go8(8'd9, 8'd4, lat, bc);
    total++;
    if (lat !== 9 || s8_q !== 8'd2 || s8_r !== 8'd1 || s8_z !== 1'b0) begin
      bad++;
      $display("FAIL after_zero got lat=%0d q=%0d r=%0d z=%b want lat=9 q=2 r=1 z=0", lat, s8_q, s8_r, s8_z);
    end
  endtask
  task automatic test_ignore;
    int lat;
    bit seen;
    @(posedge clk); #1;
    s8_a = 200;
    s8_b = 3;
    s8_start = 1;
    @(posedge clk); #1;
    s8_start = 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      s8_start = (k == 4);
      if (k == 4) begin
        s8_a = 50;
        s8_b = 5;
      end
      if (s8_done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    s8_start = 0;
    total++;
    if (lat !== 9 || s8_q !== 8'd66 || s8_r !== 8'd2 || s8_z !== 1'b0) begin
      bad++;
      $display("FAIL ignore_busy got lat=%0d q=%0d r=%0d z=%b want lat=9 q=66 r=2 z=0", lat, s8_q, s8_r, s8_z);
    end
    s8_a = 50;
    s8_b = 5;
    s8_start = 1;
    @(posedge clk); #1;
    s8_start = 0;
    total++;
    if (s8_busy !== 1'b0 || s8_done !== 1'b0) begin
      bad++;
      $display("FAIL ignore_done got busy=%b done=%b want busy=0 done=0", s8_busy, s8_done);
    end
    s8_a = 9;
    s8_b = 2;
    s8_start = 1;
    @(posedge clk); #1;
    s8_start = 0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      if (s8_done) begin
        seen = 1;
        break;
      end
      total++;
      if (s8_q !== 8'd66 || s8_r !== 8'd2 || s8_z !== 1'b0) begin
        bad++;
        $display("FAIL hold cycle %0d got q=%0d r=%0d z=%b want q=66 r=2 z=0", k, s8_q, s8_r, s8_z);
      end
      @(posedge clk); #1;
    end
    total++;
    if (!seen || s8_q !== 8'd4 || s8_r !== 8'd1) begin
      bad++;
      $display("FAIL hold_result got seen=%0d q=%0d r=%0d want seen=1 q=4 r=1", seen, s8_q, s8_r);
    end
  endtask
  task automatic test_abort;
    int lat, bc, dn;
    @(posedge clk); #1;
    s8_a = 100;
    s8_b = 7;
    s8_start = 1;
    @(posedge clk); #1;
    s8_start = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++;
    if ({s8_busy, s8_done, s8_q, s8_r, s8_z} !== 19'b0) begin
      bad++;
      $display("FAIL abort got busy=%b done=%b q=%0d r=%0d z=%b want all 0", s8_busy, s8_done, s8_q, s8_r, s8_z);
    end
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (s8_done || s8_busy) dn++;
      @(posedge clk); #1;
    end
    total++;
    if (dn !== 0) begin
      bad++;
      $display("FAIL abort_quiet got active_cycles=%0d want 0", dn);
    end
    go8(8'd100, 8'd7, lat, bc);
    total++;
    if (lat !== 9 || s8_q !== 8'd14 || s8_r !== 8'd2 || s8_z !== 1'b0) begin
      bad++;
      $display("FAIL after_abort got lat=%0d q=%0d r=%0d z=%b want lat=9 q=14 r=2 z=0", lat, s8_q, s8_r, s8_z);
    end
  endtask
  task automatic test_random8;
    int lat, bc, elat, ebc;
    logic [7:0] a, b, eq, er;
    logic ez;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      eq = (b == 0) ? 8'hff : a / b;
      er = (b == 0) ? a : a % b;
      ez = b == 0;
      elat = (b == 0) ? 1 : 9;
      ebc = (b == 0) ? 0 : 8;
      go8(a, b, lat, bc);
      total++;
      if (lat !== elat || bc !== ebc || s8_q !== eq || s8_r !== er || s8_z !== ez) begin
        bad++;
        $display("FAIL rand8 %0d/%0d got lat=%0d busy=%0d q=%0d r=%0d z=%b want lat=%0d busy=%0d q=%0d r=%0d z=%b",
                 a, b, lat, bc, s8_q, s8_r, s8_z, elat, ebc, eq, er, ez);
      end
    end
  endtask
  task automatic test_random16;
    int lat, bc, elat, ebc;
    logic [15:0] a, b, eq, er;
    logic ez;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'd0;
        1, 2: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      eq = (b == 0) ? 16'hffff : a / b;
      er = (b == 0) ? a : a % b;
      ez = b == 0;
      elat = (b == 0) ? 1 : 17;
      ebc = (b == 0) ? 0 : 16;
      go16(a, b, lat, bc);
      total++;
      if (lat !== elat || bc !== ebc || s16_q !== eq || s16_r !== er || s16_z !== ez) begin
        bad++;
        $display("FAIL rand16 %0d/%0d got lat=%0d busy=%0d q=%0d r=%0d z=%b want lat=%0d busy=%0d q=%0d r=%0d z=%b",
                 a, b, lat, bc, s16_q, s16_r, s16_z, elat, ebc, eq, er, ez);
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_div_zero;
    test_ignore;
    test_abort;
    test_random8;
    test_random16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
